setup_window_checker: RTL

Cycle-level setup-check monitor that sits directly downstream of the timing-checked DUT cells. It watches the DUT's data pin (`in`) and reference pin (`out`) and reports every reference rising edge that arrives fewer than `SETUP_CYCLES` clocks after the last data transition. It is a synthesizable, clocked counterpart of the `$setup(in, out, 2)` specify check, so setup violations remain visible in gate-free, emulation and SDF-less runs.

---
 rtl/setup_chk_pkg.sv | 14 +
 rtl/sig_edge_det.sv | 26 ++
 rtl/setup_window_checker.sv | 122 ++++++++++++
 3 files changed

// File: rtl/setup_chk_pkg.sv
// Shared types and default parameters for the setup-window checker slice.
package setup_chk_pkg;

    // IDLE: no data transition seen yet. ARMED: the gap counter is running.
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } chk_state_t;

    localparam int SETUP_CYCLES_DEF = 2;
    localparam int CNT_W_DEF        = 8;
    localparam int VIOL_W_DEF       = 16;

endpackage

// File: rtl/sig_edge_det.sv
// Edge detector for one DUT pin.
// It keeps the previous-cycle sample and reports any transition or a rising edge.
module sig_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic any_edge,
    output logic rise
);

    logic sig_q;

    // Previous-cycle sample of the pin.
    // It keeps sampling through a clear, so no spurious edge appears after one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign any_edge = sig ^ sig_q;
    assign rise     = sig & ~sig_q;

endmodule

// File: rtl/setup_window_checker.sv
// Clocked counterpart of a $setup(data, ref, SETUP_CYCLES) specify check.
// Every reference rising edge that arrives too soon after the last data
// transition is flagged. The slack of each recorded edge is reported, and
// violations are counted with a saturating counter.
module setup_window_checker
    import setup_chk_pkg::*;
#(
    parameter int SETUP_CYCLES = SETUP_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int VIOL_W       = VIOL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_in,
    input  logic              ref_in,
    input  logic              enable,
    input  logic              clear,
    output logic              armed,
    output logic              viol_pulse,
    output logic [CNT_W-1:0]  last_slack,
    output logic [VIOL_W-1:0] viol_count,
    output logic              viol_sat
);

    localparam logic [CNT_W-1:0]  GAP_MAX  = {CNT_W{1'b1}};
    localparam logic [VIOL_W-1:0] VIOL_MAX = {VIOL_W{1'b1}};
    localparam logic [CNT_W-1:0]  SETUP_LIM = CNT_W'(SETUP_CYCLES);

    chk_state_t       state;
    logic [CNT_W-1:0] gap;

    logic             data_evt;
    logic             data_rise_unused;
    logic             ref_edge_unused;
    logic             ref_rise;

    logic [CNT_W-1:0] slack;
    logic             ref_eval;
    logic             is_viol;

    sig_edge_det u_data_edge (
        .clk      (clk),
        .rst      (rst),
        .sig      (data_in),
        .any_edge (data_evt),
        .rise     (data_rise_unused)
    );

    sig_edge_det u_ref_edge (
        .clk      (clk),
        .rst      (rst),
        .sig      (ref_in),
        .any_edge (ref_edge_unused),
        .rise     (ref_rise)
    );

    // A data transition in the same cycle as the reference edge means zero slack.
    // A reference edge counts once armed, or together with the first data event.
    assign slack    = data_evt ? '0 : gap;
    assign ref_eval = ref_rise & ((state == ARMED) | data_evt);
    assign is_viol  = (slack < SETUP_LIM);

    // Single FSM block: state, gap counter and all registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gap        <= '0;
            armed      <= 1'b0;
            viol_pulse <= 1'b0;
            last_slack <= '0;
            viol_count <= '0;
            viol_sat   <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            gap        <= '0;
            armed      <= 1'b0;
            viol_pulse <= 1'b0;
            last_slack <= '0;
            viol_count <= '0;
            viol_sat   <= 1'b0;
        end else begin
            viol_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (data_evt) begin
                        state <= ARMED;
                        armed <= 1'b1;
                        gap   <= CNT_W'(1);
                    end
                end
                ARMED: begin
                    armed <= 1'b1;
                    if (data_evt) begin
                        gap <= CNT_W'(1);
                    end else if (gap != GAP_MAX) begin
                        gap <= gap + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    armed <= 1'b0;
                    gap   <= '0;
                end
            endcase

            if (ref_eval && enable) begin
                last_slack <= slack;
                if (is_viol) begin
                    viol_pulse <= 1'b1;
                    if (viol_count != VIOL_MAX) begin
                        viol_count <= viol_count + VIOL_W'(1);
                        if (viol_count + VIOL_W'(1) == VIOL_MAX) begin
                            viol_sat <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
